// File: rtl/key_pkg.sv
// Shared key ids and event layout for the keyboard event path.
// key_event_t is the default-width (16-bit timestamp) view of a queued event.
package key_pkg;

  localparam int KEY_A     = 0;
  localparam int KEY_S     = 1;
  localparam int KEY_K     = 2;
  localparam int KEY_L     = 3;
  localparam int KEY_ENTER = 4;
  localparam int NUM_KEYS  = 5;
  localparam int KEY_ID_W  = 3;
  localparam int KEY_TS_W  = 16;

  typedef struct packed {
    logic                press;
    logic [KEY_ID_W-1:0] key;
    logic [KEY_TS_W-1:0] ts;
  } key_event_t;

  // Isolates the lowest set bit, giving fixed priority to the lowest key id.
  function automatic logic [NUM_KEYS-1:0] lowest_one(input logic [NUM_KEYS-1:0] req);
    return req & (~req + {{(NUM_KEYS-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key level filter: a raw level must disagree with the held level for
// DEB_CYC consecutive cycles before it is accepted.
module key_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw_i,
  output logic held_o,
  output logic change_o
);

  localparam logic [7:0] LAST = 8'(DEB_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       held_q, held_d;
  logic       differ;

  always_comb begin
    differ   = raw_i ^ held_q;
    change_o = differ && (cnt_q == LAST);
    cnt_d    = '0;
    held_d   = held_q;
    if (change_o) begin
      held_d = raw_i;
    end else if (differ) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      held_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
    end
  end

  assign held_o = held_q;

endmodule

// File: rtl/key_event_queue.sv
// Debounces the five key levels, timestamps press/release edges and queues
// them in a small FIFO drained through a valid/ready handshake.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                a,
  input  logic                s,
  input  logic                k,
  input  logic                l,
  input  logic                enter,
  input  logic                tick,
  input  logic                ts_clr,
  output logic [NUM_KEYS-1:0] held,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ev_press,
  output logic [KEY_ID_W-1:0] ev_key,
  output logic [TS_W-1:0]     ev_ts,
  output logic [TS_W-1:0]     ts_now,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                press;
    logic [KEY_ID_W-1:0] key;
    logic [TS_W-1:0]     ts;
  } ev_t;

  logic [NUM_KEYS-1:0] raw, change, grant, pending_q, pending_d;
  ev_t                 slot_q [NUM_KEYS];
  ev_t                 slot_d [NUM_KEYS];
  ev_t                 mem_q  [DEPTH];
  ev_t                 head, push_ev;
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q, cnt_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic                ovf_q, ovf_d;
  logic                pop, push, can_push, lost;

  assign raw = {enter, l, k, s, a};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk_in   (clk_in),
      .rst      (rst),
      .raw_i    (raw[gi]),
      .held_o   (held[gi]),
      .change_o (change[gi])
    );
  end

  // A slot being pushed this cycle is not lost when its key changes again.
  always_comb begin
    pop      = (cnt_q != '0) && ev_ready;
    can_push = (cnt_q != (AW+1)'(DEPTH)) || pop;
    grant    = can_push ? lowest_one(pending_q) : '0;
    push     = |grant;
    push_ev  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (grant[i]) push_ev = slot_q[i];
    end
    pending_d = (pending_q & ~grant) | change;
    lost      = |(change & pending_q & ~grant);
    slot_d    = slot_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (change[i]) slot_d[i] = '{press: raw[i], key: KEY_ID_W'(i), ts: ts_q};
    end
    ts_d  = ts_clr ? '0 : (tick ? ts_q + 1'b1 : ts_q);
    ovf_d = lost | (ovf_q & ~ts_clr);
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) slot_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ts_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      slot_q    <= slot_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q     <= cnt_d;
      ts_q      <= ts_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= push_ev;
  end

  assign head     = mem_q[rd_q];
  assign ev_valid = (cnt_q != '0);
  assign ev_press = ev_valid & head.press;
  assign ev_key   = ev_valid ? head.key : '0;
  assign ev_ts    = ev_valid ? head.ts  : '0;
  assign ts_now   = ts_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue; a queue-based reference
// model predicts events, a negedge monitor compares the DUT against it.
module tb_key_event_queue;
  import key_pkg::*;

  localparam int DEB   = 4;
  localparam int TSW   = 16;
  localparam int DEPTH = 8;

  logic clk_in = 0, rst = 1;
  logic a = 0, s = 0, k = 0, l = 0, enter = 0, tick = 0, ts_clr = 0, ev_ready = 0;
  logic [NUM_KEYS-1:0] held;
  logic                ev_valid, ev_press, overflow;
  logic [KEY_ID_W-1:0] ev_key;
  logic [TSW-1:0]      ev_ts, ts_now;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit press;
    int key;
    int ts;
  } exp_t;

  exp_t exp_q[$];
  bit [4:0] mheld;
  int       dcnt [5];
  bit       pend [5];
  exp_t     slot [5];
  int       mcount;
  int       mts;
  bit       movf;

  always #5 clk_in = ~clk_in;

  key_event_queue #(.DEB_CYC(DEB), .TS_W(TSW), .DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .a        (a),
    .s        (s),
    .k        (k),
    .l        (l),
    .enter    (enter),
    .tick     (tick),
    .ts_clr   (ts_clr),
    .held     (held),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_press (ev_press),
    .ev_key   (ev_key),
    .ev_ts    (ev_ts),
    .ts_now   (ts_now),
    .overflow (overflow)
  );

  function automatic void checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: consecutive-differ counting, pending slots, FIFO occupancy.
  task automatic modelStep();
    bit [4:0] raw;
    bit [4:0] chg;
    bit       pop, lost;
    int       g;
    raw  = {enter, l, k, s, a};
    chg  = '0;
    lost = 0;
    g    = -1;
    for (int i = 0; i < 5; i++) begin
      if (raw[i] != mheld[i]) begin
        dcnt[i]++;
        if (dcnt[i] == DEB) begin
          chg[i]   = 1;
          dcnt[i]  = 0;
          mheld[i] = raw[i];
        end
      end else begin
        dcnt[i] = 0;
      end
    end
    pop = (mcount > 0) && ev_ready;
    if (mcount < DEPTH || pop)
      for (int i = 0; i < 5; i++) if (pend[i] && g < 0) g = i;
    if (pop) mcount--;
    if (g >= 0) begin
      exp_q.push_back(slot[g]);
      mcount++;
      pend[g] = 0;
    end
    for (int i = 0; i < 5; i++) begin
      if (chg[i]) begin
        if (pend[i]) lost = 1;
        pend[i] = 1;
        slot[i] = '{press: raw[i], key: i, ts: mts};
      end
    end
    movf = lost | (movf & !ts_clr);
    if (ts_clr) mts = 0;
    else if (tick) mts = (mts + 1) % (1 << TSW);
  endtask

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      mheld  = '0;
      mcount = 0;
      mts    = 0;
      movf   = 0;
      for (int i = 0; i < 5; i++) begin
        dcnt[i] = 0;
        pend[i] = 0;
      end
    end else begin
      modelStep();
    end
  end

  // Monitor: pops the scoreboard whenever the DUT head is accepted.
  always @(negedge clk_in) begin
    checkOutput("held", held, mheld);
    checkOutput("ev_valid", ev_valid, mcount != 0);
    checkOutput("ts_now", ts_now, mts);
    checkOutput("overflow", overflow, movf);
    if (ev_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL ev_unexpected: got key %0d press %0d, expected no event", ev_key, ev_press);
      end else begin
        checkOutput("ev_press", ev_press, exp_q[0].press);
        checkOutput("ev_key", ev_key, exp_q[0].key);
        checkOutput("ev_ts", ev_ts, exp_q[0].ts);
        if (ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit [4:0] keys, input bit tk, input bit clr,
                               input bit rdy, input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
      {enter, l, k, s, a} = keys;
      tick     = tk;
      ts_clr   = clr;
      ev_ready = rdy;
    end
  endtask

  initial begin
    bit [4:0] cur;
    int hc, vc, nv;
    int vkey [3];
    int vts  [3];
    int vcyc [3];
    #1 rst = 0;
    applyStimulus('0, 0, 0, 0, 3);
    #1;
    checkOutput("rst_held", held, 0);
    checkOutput("rst_valid", ev_valid, 0);
    checkOutput("rst_press", ev_press, 0);
    checkOutput("rst_key", ev_key, 0);
    checkOutput("rst_ts", ev_ts, 0);
    checkOutput("rst_ts_now", ts_now, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1;

    // Single press on lane 0 at timestamp 7, then release.
    applyStimulus('0, 1, 0, 0, 7);
    applyStimulus(5'b00001, 0, 0, 0, 1);
    hc = 0;
    vc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_in);
      #1;
      if (held[0] && hc == 0) hc = c;
      if (ev_valid) begin
        vc = c;
        break;
      end
    end
    checkOutput("held_latency", hc, DEB);
    checkOutput("valid_latency", vc, DEB + 1);
    checkOutput("first_press", ev_press, 1);
    checkOutput("first_key", ev_key, KEY_A);
    checkOutput("first_ts", ev_ts, 7);
    applyStimulus('0, 0, 0, 1, 12);

    // Short glitch on lane 1 must be filtered out.
    applyStimulus(5'b00010, 0, 0, 1, 3);
    applyStimulus('0, 0, 0, 1, 8);
    checkOutput("glitch_held", held[1], 0);
    checkOutput("glitch_valid", ev_valid, 0);

    // Three simultaneous presses drain in key-id order, back to back.
    applyStimulus(5'b10101, 0, 0, 1, 1);
    nv = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_in);
      #1;
      if (ev_valid && nv < 3) begin
        vkey[nv] = ev_key;
        vts[nv]  = ev_ts;
        vcyc[nv] = c;
        nv++;
      end
    end
    checkOutput("multi_count", nv, 3);
    if (nv == 3) begin
      checkOutput("multi_key0", vkey[0], KEY_A);
      checkOutput("multi_key1", vkey[1], KEY_K);
      checkOutput("multi_key2", vkey[2], KEY_ENTER);
      checkOutput("multi_ts", vts[2], vts[0]);
      checkOutput("multi_consec", vcyc[2] - vcyc[0], 2);
    end
    applyStimulus('0, 0, 0, 1, 15);

    // Ten edges with the consumer stalled, then an overwrite of a waiting slot.
    cur = '0;
    for (int i = 0; i < 10; i++) begin
      cur[i % 5] = ~cur[i % 5];
      applyStimulus(cur, 0, 0, 0, DEB + 2);
    end
    checkOutput("stall_valid", ev_valid, 1);
    cur[3] = ~cur[3];
    applyStimulus(cur, 0, 0, 0, DEB + 2);
    checkOutput("overwrite_ovf", overflow, 1);
    applyStimulus(cur, 0, 0, 1, 30);
    checkOutput("drain_valid", ev_valid, 0);
    checkOutput("drain_queue", exp_q.size(), 0);

    // Clear wins over tick, then a full timestamp wrap.
    applyStimulus(cur, 1, 1, 1, 1);
    @(posedge clk_in);
    #1;
    checkOutput("clr_ts", ts_now, 0);
    checkOutput("clr_ovf", overflow, 0);
    applyStimulus(cur, 1, 0, 1, 65535);
    applyStimulus(cur, 0, 0, 1, 1);
    #1;
    checkOutput("ts_max", ts_now, 16'hFFFF);
    applyStimulus(cur, 1, 0, 1, 1);
    applyStimulus(cur, 0, 0, 1, 1);
    #1;
    checkOutput("ts_wrap", ts_now, 0);

    // Randomized phase.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) cur[$urandom_range(4)] ^= 1'b1;
      applyStimulus(cur, $urandom_range(3) == 0, $urandom_range(63) == 0,
                    (c % 200 < 120) ? 1'($urandom_range(1)) : 1'b0, 1);
    end
    applyStimulus('0, 0, 0, 1, 60);
    checkOutput("rand_drain", exp_q.size(), 0);

    // Reset in the middle of a burst discards everything.
    applyStimulus(5'b00111, 0, 0, 0, DEB + 5);
    checkOutput("burst_valid", ev_valid, 1);
    @(posedge clk_in);
    #2;
    rst = 0;
    {enter, l, k, s, a} = '0;
    #1;
    checkOutput("mid_rst_valid", ev_valid, 0);
    checkOutput("mid_rst_held", held, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    applyStimulus('0, 0, 0, 1, 3);
    rst = 1;
    applyStimulus('0, 0, 0, 1, 12);
    checkOutput("post_rst_valid", ev_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
